// File: rtl/fifo_block_reader_if.sv
// FIFO read-side and sample-stream signals used by fifo_block_reader.
// The master modport is the reader. The slave modport is its environment,
// which is the delay FIFO plus the downstream residual calculator.
interface fifo_block_reader_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
);
    logic                          iFifoEmpty;
    logic        [COUNT_WIDTH-1:0] iFifoUsedw;
    logic        [DATA_WIDTH-1:0]  iFifoQ;
    logic                          oFifoRdreq;
    logic signed [DATA_WIDTH-1:0]  oSample;
    logic                          oValid;
    logic                          iReady;
    logic                          oFirst;
    logic                          oLast;

    modport master (
        input  iFifoEmpty,
        input  iFifoUsedw,
        input  iFifoQ,
        input  iReady,
        output oFifoRdreq,
        output oSample,
        output oValid,
        output oFirst,
        output oLast
    );

    modport slave (
        output iFifoEmpty,
        output iFifoUsedw,
        output iFifoQ,
        output iReady,
        input  oFifoRdreq,
        input  oSample,
        input  oValid,
        input  oFirst,
        input  oLast
    );
endinterface

// File: rtl/fifo_block_reader.sv
// Drains one block of BLOCK_SIZE samples from the sample delay FIFO for each
// iStart. It presents the block as a valid/ready stream with first/last markers.
// A 2-entry buffer covers the FIFO's one-cycle read latency, so reads only go
// out when the data they return is certain to have a free slot.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no block in progress, waiting for iStart
// WAIT_FILL | block armed, waiting for the FIFO to hold a whole block
// READ      | issuing FIFO reads until BLOCK_SIZE have gone out
// DRAIN     | all reads issued, emptying the buffer downstream
// DONE      | last sample accepted, oDone pulse, then back to IDLE
module fifo_block_reader #(
    parameter int BLOCK_SIZE  = 4096,
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iStart,
    fifo_block_reader_if.master bus,
    output logic                oBusy,
    output logic                oDone
);

    // Counters must be able to hold BLOCK_SIZE itself, not just BLOCK_SIZE-1.
    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);
    localparam logic [CNT_W-1:0]       LAST_IDX   = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0]       BLOCK_CNT  = CNT_W'(BLOCK_SIZE);
    localparam logic [COUNT_WIDTH-1:0] FILL_LEVEL = COUNT_WIDTH'(BLOCK_SIZE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FILL = 3'd1,
        READ      = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             rd_issued_q, rd_issued_d;
    logic [CNT_W-1:0]             tx_count_q, tx_count_d;
    logic [1:0]                   buf_count_q, buf_count_d;
    logic signed [DATA_WIDTH-1:0] buf0_q, buf0_d;   // head, drives oSample
    logic signed [DATA_WIDTH-1:0] buf1_q, buf1_d;   // second entry
    logic                         inflight_q;       // rdreq was issued last cycle

    logic       rdreq;
    logic       pop;
    logic       capture;
    logic [2:0] occupancy;

    assign bus.oValid     = (buf_count_q != 2'd0);
    assign bus.oSample    = buf0_q;
    assign bus.oFirst     = bus.oValid && (tx_count_q == '0);
    assign bus.oLast      = bus.oValid && (tx_count_q == LAST_IDX);
    assign bus.oFifoRdreq = rdreq;
    assign oBusy          = (state_q != IDLE);
    assign oDone          = (state_q == DONE);

    assign pop     = bus.oValid && bus.iReady;
    assign capture = inflight_q;

    // Entries the buffer is committed to after this cycle's pop, counting
    // the read whose data is still in flight from the FIFO.
    assign occupancy = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Sequencing: block start, fill wait, read issue and end-of-block detection.
    always_comb begin
        state_d     = state_q;
        rd_issued_d = rd_issued_q;
        tx_count_d  = tx_count_q;
        rdreq       = 1'b0;

        if (pop) begin
            tx_count_d = tx_count_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d     = WAIT_FILL;
                    rd_issued_d = '0;
                    tx_count_d  = '0;
                end
            end

            WAIT_FILL: begin
                if (bus.iFifoUsedw >= FILL_LEVEL) begin
                    state_d = READ;
                end
            end

            READ: begin
                rdreq = !bus.iFifoEmpty
                        && (rd_issued_q < BLOCK_CNT)
                        && (occupancy < 3'd2);
                if (rdreq) begin
                    rd_issued_d = rd_issued_q + 1'b1;
                    if (rd_issued_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (pop && (tx_count_q == LAST_IDX)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output buffer: capture FIFO data into the next free slot and pop from the head.
    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        buf_count_d = buf_count_q;

        case ({capture, pop})
            2'b01: begin
                buf0_d      = buf1_q;
                buf_count_d = buf_count_q - 2'd1;
            end
            2'b10: begin
                if (buf_count_q == 2'd0) begin
                    buf0_d = bus.iFifoQ;
                end else begin
                    buf1_d = bus.iFifoQ;
                end
                buf_count_d = buf_count_q + 2'd1;
            end
            2'b11: begin
                // Count is unchanged. The new word lands behind whatever remains.
                if (buf_count_q == 2'd1) begin
                    buf0_d = bus.iFifoQ;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.iFifoQ;
                end
            end
            default: begin
                buf_count_d = buf_count_q;
            end
        endcase
    end

    // Control registers. Reset abandons any block and the read in flight.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q     <= IDLE;
            rd_issued_q <= '0;
            tx_count_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_issued_q <= rd_issued_d;
            tx_count_q  <= tx_count_d;
            inflight_q  <= rdreq;
        end
    end

    // Buffer registers.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            buf0_q      <= '0;
            buf1_q      <= '0;
            buf_count_q <= 2'd0;
        end else begin
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            buf_count_q <= buf_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_block_reader.sv
// Bench for fifo_block_reader. It contains a behavioural delay FIFO (a queue
// with a registered read port) and a stream monitor. The expected output of
// every block is the sequence of words written to the FIFO for that block.
module tb_fifo_block_reader;
    localparam int BS        = 4096;
    localparam int DW        = 16;
    localparam int CW        = 16;
    localparam int SRC_DEPTH = 65536;
    localparam int OUT_DEPTH = 8192;

    logic clk         = 1'b0;
    logic rst         = 1'b1;
    logic start       = 1'b0;
    logic ready       = 1'b0;
    logic force_empty = 1'b0;
    logic busy;
    logic done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_block_reader_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    fifo_block_reader #(
        .BLOCK_SIZE (BS),
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW)
    ) dut (
        .iClock(clk),
        .iReset(rst),
        .iStart(start),
        .bus   (bus),
        .oBusy (busy),
        .oDone (done)
    );

    // FIFO model
    logic [DW-1:0] src_mem [SRC_DEPTH];
    int            src_wr    = 0;
    int            src_rd    = 0;
    logic          trickle   = 1'b0;
    int            flush_req = 0;
    int            flush_ack = 0;
    logic [DW-1:0] fifo_q [$];
    int            fifo_cnt  = 0;
    logic [DW-1:0] fifo_rdata = '0;
    int            rd_empty_err = 0;

    assign bus.iFifoEmpty = (fifo_cnt == 0) || force_empty;
    assign bus.iFifoUsedw = CW'(fifo_cnt);
    assign bus.iFifoQ     = fifo_rdata;
    assign bus.iReady     = ready;

    always @(posedge clk) begin
        if (bus.oFifoRdreq) begin
            if (bus.iFifoEmpty || fifo_q.size() == 0) rd_empty_err++;
            else fifo_rdata <= fifo_q.pop_front();
        end
        if (flush_req != flush_ack) begin
            fifo_q.delete();
            flush_ack = flush_req;
        end
        if (trickle) begin
            if (src_rd < src_wr) begin
                fifo_q.push_back(src_mem[src_rd]);
                src_rd++;
            end
        end else begin
            while (src_rd < src_wr) begin
                fifo_q.push_back(src_mem[src_rd]);
                src_rd++;
            end
        end
        fifo_cnt <= fifo_q.size();
    end

    // Stream monitor
    int            cyc = 0;
    int            clr_req = 0;
    int            clr_seen = 0;
    logic [DW-1:0] out_data  [OUT_DEPTH];
    logic          out_first [OUT_DEPTH];
    logic          out_last  [OUT_DEPTH];
    int            tx_cnt = 0;
    int            first_tx_cyc = -1;
    int            last_tx_cyc = -1;
    int            rd_cnt = 0;
    int            first_rd_cyc = -1;
    int            first_rd_usedw = -1;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            usedw_full_cyc = -1;
    int            stall_err = 0;
    int            occ_err = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_s = '0;
    logic          prev_f = 1'b0;
    logic          prev_l = 1'b0;
    int            bad_idx = 0;

    always @(negedge clk) begin
        cyc++;
        if (clr_req != clr_seen) begin
            tx_cnt = 0; first_tx_cyc = -1; last_tx_cyc = -1;
            rd_cnt = 0; first_rd_cyc = -1; first_rd_usedw = -1;
            done_cnt = 0; done_cyc = -1; usedw_full_cyc = -1;
            stall_err = 0; occ_err = 0; stall_prev = 1'b0;
            clr_seen = clr_req;
        end
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (bus.oValid !== 1'b1 || bus.oSample !== prev_s ||
                               bus.oFirst !== prev_f || bus.oLast !== prev_l))
                stall_err++;
            stall_prev = bus.oValid && !bus.iReady;
            prev_s = bus.oSample;
            prev_f = bus.oFirst;
            prev_l = bus.oLast;
            if (bus.oValid && bus.iReady) begin
                if (tx_cnt < OUT_DEPTH) begin
                    out_data[tx_cnt]  = bus.oSample;
                    out_first[tx_cnt] = bus.oFirst;
                    out_last[tx_cnt]  = bus.oLast;
                end
                if (tx_cnt == 0) first_tx_cyc = cyc;
                last_tx_cyc = cyc;
                tx_cnt++;
            end
            if (bus.oFifoRdreq) begin
                if (rd_cnt == 0) begin
                    first_rd_cyc   = cyc;
                    first_rd_usedw = int'(bus.iFifoUsedw);
                end
                rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (usedw_full_cyc < 0 && bus.iFifoUsedw >= CW'(BS)) usedw_full_cyc = cyc;
            if (rd_cnt - tx_cnt > 2) occ_err++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    // Reference: transfer i must carry word base+i, with first only at i=0 and last only at i=BS-1.
    function automatic int seq_errors(input int base);
        int errs = 0;
        for (int i = 0; i < tx_cnt && i < OUT_DEPTH; i++) begin
            if (out_data[i] !== src_mem[base + i] ||
                out_first[i] !== (i == 0) || out_last[i] !== (i == BS - 1)) begin
                if (errs == 0) bad_idx = i;
                errs++;
            end
        end
        return errs;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush_fifo();
        flush_req++;
        tick(2);
    endtask

    task automatic load_words(input int n, input logic seq, input int seq_base);
        for (int i = 0; i < n; i++) begin
            src_mem[src_wr] = seq ? DW'(seq_base + i) : DW'($urandom);
            src_wr++;
        end
    endtask

    task automatic clear_mon();
        clr_req++;
        tick(1);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic rand_ready, output logic timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (rand_ready) ready = ($urandom_range(0, 3) != 0);
            tick(1);
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; start = 1'b0;
        tick(2);
        n_assert++;
        if ({busy, done, bus.oValid, bus.oFirst, bus.oLast, bus.oFifoRdreq} !== 6'b0 || bus.oSample !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b valid=%b first=%b last=%b rdreq=%b sample=%h, required all 0",
                     busy, done, bus.oValid, bus.oFirst, bus.oLast, bus.oFifoRdreq, bus.oSample);
        end
        rst = 1'b0;
        load_words(BS, 1'b0, 0);
        clear_mon();
        ready = 1'b1;
        tick(100);
        n_assert++;
        if (rd_cnt !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_rdreq: rdreqs=%0d busy=%b, required 0 and 0", rd_cnt, busy);
        end
        flush_fifo();
    endtask

    task automatic test_full_rate();
        int base;
        int errs;
        logic to;
        flush_fifo();
        base = src_wr;
        load_words(BS, 1'b1, 0);
        tick(2);
        clear_mon();
        ready = 1'b1;
        start_pulse();
        wait_done(12000, 1'b0, to);
        tick(3);
        n_assert++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: timed_out=%b, required 0", to); end
        n_assert++;
        if (tx_cnt !== BS) begin n_fail++; $display("FAIL full_tx_count: got %0d, required %0d", tx_cnt, BS); end
        errs = seq_errors(base);
        n_assert++;
        if (errs !== 0) begin
            n_fail++;
            $display("FAIL full_sequence: %0d bad transfers, first at %0d (got %h f%b l%b, required %h)",
                     errs, bad_idx, out_data[bad_idx], out_first[bad_idx], out_last[bad_idx], src_mem[base + bad_idx]);
        end
        n_assert++;
        if (last_tx_cyc - first_tx_cyc !== BS - 1) begin
            n_fail++; $display("FAIL full_consecutive: span %0d cycles, required %0d", last_tx_cyc - first_tx_cyc, BS - 1);
        end
        n_assert++;
        if (done_cyc !== last_tx_cyc + 1 || done_cnt !== 1) begin
            n_fail++; $display("FAIL full_done: done at %0d count %0d, required at %0d count 1", done_cyc, done_cnt, last_tx_cyc + 1);
        end
        n_assert++;
        if (rd_cnt !== BS) begin n_fail++; $display("FAIL full_rdreq_count: got %0d, required %0d", rd_cnt, BS); end
        n_assert++;
        if (first_tx_cyc - first_rd_cyc !== 2) begin
            n_fail++; $display("FAIL full_latency: first valid %0d cycles after first rdreq, required 2", first_tx_cyc - first_rd_cyc);
        end
        n_assert++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: busy=%b, required 0", busy); end
    endtask

    task automatic test_wait_fill();
        int base;
        int errs;
        logic to;
        flush_fifo();
        base = src_wr;
        load_words(100, 1'b0, 0);
        tick(2);
        clear_mon();
        ready = 1'b1;
        start_pulse();
        n_assert++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: busy=%b after iStart, required 1", busy); end
        tick(5);
        n_assert++;
        if (rd_cnt !== 0) begin n_fail++; $display("FAIL fill_early_rdreq: got %0d rdreqs, required 0", rd_cnt); end
        trickle = 1'b1;
        load_words(BS - 100, 1'b0, 0);
        wait_done(20000, 1'b0, to);
        trickle = 1'b0;
        tick(3);
        n_assert++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL fill_timeout: timed_out=%b, required 0", to); end
        n_assert++;
        if (first_rd_usedw !== BS || usedw_full_cyc < 0 || first_rd_cyc - usedw_full_cyc !== 1) begin
            n_fail++;
            $display("FAIL fill_first_rdreq: usedw=%0d at first rdreq, %0d cycles after fill, required %0d and 1",
                     first_rd_usedw, first_rd_cyc - usedw_full_cyc, BS);
        end
        errs = seq_errors(base);
        n_assert++;
        if (errs !== 0 || tx_cnt !== BS || rd_cnt !== BS) begin
            n_fail++;
            $display("FAIL fill_drain: %0d bad (first at %0d), tx=%0d rd=%0d, required 0 bad and %0d/%0d",
                     errs, bad_idx, tx_cnt, rd_cnt, BS, BS);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int errs;
        int hold_left;
        logic hold_done;
        logic to;
        logic [3:0] pat;
        pat = 4'b1001;
        flush_fifo();
        base = src_wr;
        load_words(BS, 1'b0, 0);
        tick(2);
        clear_mon();
        ready = 1'b0;
        start_pulse();
        hold_left = 0;
        hold_done = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 30000; k++) begin
            if (!hold_done && tx_cnt >= 2000) begin hold_left = 50; hold_done = 1'b1; end
            if (hold_left > 0) begin ready = 1'b0; hold_left--; end
            else ready = pat[k % 4];
            start = (k == 300);
            tick(1);
            if (done === 1'b1) begin
                to = 1'b0;
                start = 1'b1;
                tick(1);
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        ready = 1'b1;
        tick(5);
        n_assert++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: timed_out=%b, required 0", to); end
        n_assert++;
        if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", stall_err); end
        n_assert++;
        if (occ_err !== 0) begin n_fail++; $display("FAIL bp_occupancy: %0d cycles above 2 outstanding, required 0", occ_err); end
        errs = seq_errors(base);
        n_assert++;
        if (errs !== 0 || tx_cnt !== BS || rd_cnt !== BS) begin
            n_fail++;
            $display("FAIL bp_sequence: %0d bad (first at %0d), tx=%0d rd=%0d, required 0 bad and %0d/%0d",
                     errs, bad_idx, tx_cnt, rd_cnt, BS, BS);
        end
        n_assert++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_start_on_done: done_count=%0d busy=%b, required 1 and 0", done_cnt, busy);
        end
    endtask

    task automatic test_underflow();
        int base;
        int errs;
        int rd_before;
        int rd_after;
        logic to;
        flush_fifo();
        base = src_wr;
        load_words(BS, 1'b0, 0);
        tick(2);
        clear_mon();
        ready = 1'b1;
        start_pulse();
        for (int k = 0; k < 10000 && rd_cnt < 1500; k++) tick(1);
        force_empty = 1'b1;
        rd_before = rd_cnt;
        tick(10);
        rd_after = rd_cnt;
        force_empty = 1'b0;
        n_assert++;
        if (rd_after !== rd_before) begin
            n_fail++; $display("FAIL uf_rdreq_while_empty: %0d rdreqs in window, required 0", rd_after - rd_before);
        end
        wait_done(12000, 1'b0, to);
        tick(3);
        errs = seq_errors(base);
        n_assert++;
        if (to !== 1'b0 || errs !== 0 || tx_cnt !== BS || rd_cnt !== BS) begin
            n_fail++;
            $display("FAIL uf_resume: timeout=%b %0d bad (first at %0d), tx=%0d rd=%0d, required 0, 0 bad, %0d/%0d",
                     to, errs, bad_idx, tx_cnt, rd_cnt, BS, BS);
        end
    endtask

    task automatic test_reset_mid_block();
        int base;
        int errs;
        int rd_hold;
        logic to;
        flush_fifo();
        load_words(BS, 1'b0, 0);
        tick(2);
        clear_mon();
        ready = 1'b1;
        start_pulse();
        for (int k = 0; k < 10000 && tx_cnt < 1000; k++) tick(1);
        rst = 1'b1;
        tick(1);
        n_assert++;
        if ({busy, done, bus.oValid, bus.oFirst, bus.oLast, bus.oFifoRdreq} !== 6'b0 || bus.oSample !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy=%b done=%b valid=%b first=%b last=%b rdreq=%b sample=%h, required all 0",
                     busy, done, bus.oValid, bus.oFirst, bus.oLast, bus.oFifoRdreq, bus.oSample);
        end
        rst = 1'b0;
        tick(1);
        rd_hold = rd_cnt;
        tick(5);
        n_assert++;
        if (busy !== 1'b0 || rd_cnt !== rd_hold) begin
            n_fail++; $display("FAIL midrst_idle: busy=%b rdreqs=%0d, required 0 and none", busy, rd_cnt - rd_hold);
        end
        flush_fifo();
        base = src_wr;
        load_words(BS, 1'b0, 0);
        tick(2);
        clear_mon();
        start_pulse();
        wait_done(30000, 1'b1, to);
        tick(3);
        errs = seq_errors(base);
        n_assert++;
        if (to !== 1'b0 || errs !== 0 || tx_cnt !== BS || rd_cnt !== BS || stall_err !== 0) begin
            n_fail++;
            $display("FAIL midrst_refill: timeout=%b %0d bad (first at %0d), tx=%0d rd=%0d stall=%0d, required 0, 0, %0d/%0d, 0",
                     to, errs, bad_idx, tx_cnt, rd_cnt, stall_err, BS, BS);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_wait_fill();
        test_backpressure();
        test_underflow();
        test_reset_mid_block();
        n_assert++;
        if (rd_empty_err !== 0) begin
            n_fail++; $display("FAIL rdreq_on_empty: %0d reads of an empty FIFO, required 0", rd_empty_err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
